// File: rtl/id_sum_pkg.sv
// -----------------------------------------------------------------------------
// id_sum_pkg
// Shared types and constants for the ID-digit sum sequencer.
//   state_t     : sequencer FSM states
//   DIGIT_W_DEF : default digit / accumulator width
//   IDX_W       : width of the consumed-digit counter
// -----------------------------------------------------------------------------
package id_sum_pkg;

    localparam int DIGIT_W_DEF = 4;
    localparam int IDX_W       = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/id_sum_sequencer_nibble_adder.sv
// -----------------------------------------------------------------------------
// nibble_adder
// W-bit combinational adder, carry-in tied low.
// Ports:
//   a, b  : in  [W-1:0] operands
//   s     : out [W-1:0] sum modulo 2^W
//   cout  : out         carry-out of the top bit
// -----------------------------------------------------------------------------
module nibble_adder
    import id_sum_pkg::*;
#(
    parameter int W = DIGIT_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/id_sum_sequencer.sv
// -----------------------------------------------------------------------------
// id_sum_sequencer
// Bounded, restartable accumulation of NUM_DIGITS student-ID digits.
// A start pulse in IDLE clears the accumulator, then NUM_DIGITS digits are
// pulled over a valid/ready handshake and added into a DIGIT_W-bit sum.
// done pulses once when the result is final; sum/ovf hold until next start.
//
// Optional feature macro: ID_SUM_SAT_EN
//   defined   : any add with carry-out saturates sum to all ones
//   undefined : sum wraps modulo 2^DIGIT_W (ovf still flags the carry)
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   start        in   begin operation (sampled only in IDLE)
//   digit_in     in   [DIGIT_W-1:0] digit from the ID generator
//   digit_valid  in   digit_in valid this cycle
//   digit_ready  out  digit consumed this cycle if digit_valid=1
//   busy         out  operation in progress (ACCUM)
//   done         out  one-cycle pulse when the result is final
//   sum          out  [DIGIT_W-1:0] accumulator
//   ovf          out  sticky carry-out flag for the current operation
//   digit_idx    out  [3:0] digits consumed so far
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for start, result held
// S_ACCUM | consuming digits, one per valid cycle
// S_DONE  | result final, done pulse, back to IDLE
// -----------------------------------------------------------------------------
module id_sum_sequencer
    import id_sum_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_W    = DIGIT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               digit_valid,
    output logic               digit_ready,
    output logic               busy,
    output logic               done,
    output logic [DIGIT_W-1:0] sum,
    output logic               ovf,
    output logic [IDX_W-1:0]   digit_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t             r_state;
    logic [DIGIT_W-1:0] r_sum;
    logic               r_ovf;
    logic [IDX_W-1:0]   r_digit_idx;
    logic               r_busy;
    logic               r_ready;
    logic               r_done;

    logic [DIGIT_W-1:0] w_add;
    logic               w_cout;
    logic [DIGIT_W-1:0] w_sum_next;

    nibble_adder #(
        .W (DIGIT_W)
    ) u_adder (
        .a    (r_sum),
        .b    (digit_in),
        .s    (w_add),
        .cout (w_cout)
    );

`ifdef ID_SUM_SAT_EN
    // A saturated sum of all ones stays put: adding 0 yields all ones with no
    // carry, adding anything else carries and re-saturates.
    assign w_sum_next = w_cout ? {DIGIT_W{1'b1}} : w_add;
`else
    assign w_sum_next = w_add;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
            r_digit_idx <= '0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state     <= S_ACCUM;
                        r_sum       <= '0;
                        r_ovf       <= 1'b0;
                        r_digit_idx <= '0;
                        r_busy      <= 1'b1;
                        r_ready     <= 1'b1;
                    end
                end

                S_ACCUM: begin
                    if (digit_valid) begin
                        r_sum       <= w_sum_next;
                        r_ovf       <= r_ovf | w_cout;
                        r_digit_idx <= r_digit_idx + IDX_W'(1);
                        if (r_digit_idx == LAST_IDX) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign digit_ready = r_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign sum         = r_sum;
    assign ovf         = r_ovf;
    assign digit_idx   = r_digit_idx;

endmodule

// File: tb/tb_id_sum_sequencer.sv
module tb_id_sum_sequencer;

    localparam int N = 8;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] digit_in;
    logic         digit_valid;
    logic         digit_ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         ovf;
    logic [3:0]   digit_idx;

    id_sum_sequencer #(
        .NUM_DIGITS (N),
        .DIGIT_W    (W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .busy        (busy),
        .done        (done),
        .sum         (sum),
        .ovf         (ovf),
        .digit_idx   (digit_idx)
    );

    always #5 clk = ~clk;

    int n_checks    = 0;
    int n_fail      = 0;
    int n_done_seen = 0;
    int n_done_exp  = 0;

    // expected result per operation: {ovf, digit_idx, sum}
    logic [8:0] sb_q[$];
    logic [8:0] sb_e;
    logic [3:0] g_dig [N];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_add(inout int s, inout int o, input int d);
        int t;
        t = s + d;
        if (t > 15) begin
            o = 1;
`ifdef ID_SUM_SAT_EN
            s = 15;
`else
            s = t - 16;
`endif
        end else begin
            s = t;
        end
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            n_done_seen++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("sb_sum", int'(sum), int'(sb_e[3:0]));
                chk("sb_ovf", int'(ovf), int'(sb_e[8]));
                chk("sb_idx", int'(digit_idx), int'(sb_e[7:4]));
            end
        end
    end

    // stall: idle cycles before each digit; start_at: digit index during which
    // start is pulsed; abort_after: digits consumed before a reset (-1 = none)
    task automatic do_run(input int stall, input int start_at, input int abort_after);
        int s = 0;
        int o = 0;
        if (abort_after < 0) begin
            for (int i = 0; i < N; i++) model_add(s, o, int'(g_dig[i]));
            sb_q.push_back({o[0], 4'(N), s[3:0]});
            n_done_exp++;
            s = 0;
            o = 0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clr_sum", int'(sum), 0);
        chk("clr_ovf", int'(ovf), 0);
        chk("clr_idx", int'(digit_idx), 0);
        chk("accum_busy", int'(busy), 1);
        chk("accum_ready", int'(digit_ready), 1);
        for (int i = 0; i < N; i++) begin
            if (i == abort_after) begin
                digit_valid = 1'b1;
                digit_in    = 4'hF;
                reset       = 1'b1;
                tick();
                reset       = 1'b0;
                chk("abort_sum", int'(sum), 0);
                chk("abort_ovf", int'(ovf), 0);
                chk("abort_idx", int'(digit_idx), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_ready", int'(digit_ready), 0);
                chk("abort_done", int'(done), 0);
                repeat (3) tick();
                chk("abort_idle_idx", int'(digit_idx), 0);
                chk("abort_idle_busy", int'(busy), 0);
                digit_valid = 1'b0;
                return;
            end
            for (int k = 0; k < stall; k++) begin
                digit_valid = 1'b0;
                digit_in    = 4'($urandom_range(1, 15));
                tick();
                chk("stall_idx", int'(digit_idx), i);
                chk("stall_sum", int'(sum), s);
            end
            digit_valid = 1'b1;
            digit_in    = g_dig[i];
            if (i == start_at) start = 1'b1;
            tick();
            start = 1'b0;
            model_add(s, o, int'(g_dig[i]));
            chk("step_idx", int'(digit_idx), i + 1);
            chk("step_sum", int'(sum), s);
            chk("step_ovf", int'(ovf), o);
        end
        digit_valid = 1'b0;
        // last transfer edge lands in DONE: done is visible right now
        chk("done_latency", int'(done), 1);
        chk("done_busy", int'(busy), 0);
        chk("done_ready", int'(digit_ready), 0);
        tick();
        chk("done_pulse_len", int'(done), 0);
        chk("hold_sum", int'(sum), s);
        chk("hold_ovf", int'(ovf), o);
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        digit_valid = 1'b0;
        digit_in    = '0;
        repeat (3) tick();
        chk("rst_sum", int'(sum), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_idx", int'(digit_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(digit_ready), 0);

        // reset beats start
        start = 1'b1;
        tick();
        chk("rst_vs_start_busy", int'(busy), 0);
        reset = 1'b0;
        start = 1'b0;

        // no transfers while IDLE
        digit_valid = 1'b1;
        digit_in    = 4'h7;
        repeat (3) tick();
        chk("idle_no_add_sum", int'(sum), 0);
        chk("idle_no_add_idx", int'(digit_idx), 0);
        chk("idle_ready", int'(digit_ready), 0);
        digit_valid = 1'b0;

        // 1..8: wraps to 4 (or saturates to 15)
        for (int i = 0; i < N; i++) g_dig[i] = 4'(i + 1);
        do_run(0, -1, -1);

        // 2,0,3 then zeros with 2-cycle stalls: 5, no carry
        for (int i = 0; i < N; i++) g_dig[i] = 4'h0;
        g_dig[0] = 4'd2;
        g_dig[2] = 4'd3;
        do_run(2, -1, -1);

        // start pulsed after 2 digits is ignored
        for (int i = 0; i < N; i++) g_dig[i] = 4'(i + 1);
        do_run(0, 2, -1);

        // back-to-back: start in the IDLE cycle right after done; 4+4 = 8
        for (int i = 0; i < N; i++) g_dig[i] = 4'h0;
        g_dig[0] = 4'd4;
        g_dig[1] = 4'd4;
        do_run(0, -1, -1);

        // reset after 3 of 8 digits
        for (int i = 0; i < N; i++) g_dig[i] = 4'(i + 1);
        do_run(0, -1, 3);

        // normal operation afterwards, random digits incl. full-range values
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) g_dig[i] = 4'($urandom_range(0, 15));
            do_run(r % 2, -1, -1);
        end

        repeat (3) tick();
        chk("done_count", n_done_seen, n_done_exp);
        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
